// File: rtl/memlog_dumper.sv
// Read-out stage for MEMLog: walks log words from address 0 and streams them LSB byte first.
// Optional build macro MEMLOG_DUMP_HEADER_EN prefixes the stream with header bytes 0xA5, 0x5A.
module memlog_dumper #(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned BRAM_DATA_WIDTH = 16,
  parameter int unsigned DUMP_WORDS      = 2**BRAM_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_start_dump,
  input  logic                         i_mem_full,
  output logic                         o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log_to_mem,
  input  logic [2*BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned WORD_W = 2 * BRAM_DATA_WIDTH;
  localparam int unsigned NBYTES = WORD_W / 8;
  localparam int unsigned BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_WORD = BRAM_ADDR_WIDTH'(DUMP_WORDS - 1);
  localparam logic [BIDX_W-1:0]          LAST_BYTE = BIDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_CAP, S_HDR, S_SEND, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] word_q, word_d;
  logic [BIDX_W-1:0]          byte_q, byte_d;
  logic [WORD_W-1:0]          cap_q, cap_d;
  logic                       read_log_q, read_log_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       tx_valid_q, tx_valid_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       xfer;
`ifdef MEMLOG_DUMP_HEADER_EN
  logic                       hdr_q, hdr_d;
`endif

  assign xfer = tx_valid_q && i_tx_ready;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      byte_q     <= '0;
      cap_q      <= '0;
      read_log_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
`ifdef MEMLOG_DUMP_HEADER_EN
      hdr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      cap_q      <= cap_d;
      read_log_q <= read_log_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
`ifdef MEMLOG_DUMP_HEADER_EN
      hdr_q      <= hdr_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    cap_d   = cap_q;
`ifdef MEMLOG_DUMP_HEADER_EN
    hdr_d   = hdr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start_dump && i_mem_full) begin
          state_d = S_REQ;
          word_d  = '0;
        end
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        cap_d  = i_data_log_from_mem;
        byte_d = '0;
`ifdef MEMLOG_DUMP_HEADER_EN
        hdr_d   = 1'b0;
        state_d = (word_q == '0) ? S_HDR : S_SEND;
`else
        state_d = S_SEND;
`endif
      end
`ifdef MEMLOG_DUMP_HEADER_EN
      S_HDR: begin
        if (xfer) begin
          hdr_d = 1'b1;
          if (hdr_q) state_d = S_SEND;
        end
      end
`endif
      S_SEND: begin
        if (xfer) begin
          if (byte_q == LAST_BYTE) begin
            if (word_q == LAST_WORD) begin
              state_d = S_DONE;
            end else begin
              word_d  = word_q + BRAM_ADDR_WIDTH'(1);
              state_d = S_REQ;
            end
          end else begin
            byte_d = byte_q + BIDX_W'(1);
            cap_d  = cap_q >> 8;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        word_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    read_log_d = (state_q == S_IDLE) && (state_d == S_REQ);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    tx_valid_d = (state_d == S_SEND) || (state_d == S_HDR);
    tx_data_d  = '0;
    if (state_d == S_SEND) tx_data_d = cap_d[7:0];
`ifdef MEMLOG_DUMP_HEADER_EN
    if (state_d == S_HDR) tx_data_d = hdr_d ? 8'h5A : 8'hA5;
`endif
  end

  assign o_read_log        = read_log_q;
  assign o_addr_log_to_mem = word_q;
  assign o_tx_data         = tx_data_q;
  assign o_tx_valid        = tx_valid_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;

endmodule
